// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-requester UART transmit scheduler.
// Frame layout is 8N1: one start bit, DATA_W payload bits, one stop bit.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DIV_W       = 14;
    localparam int UART_DEFAULT_DIV = 10416;
    localparam int UART_MIN_DIV     = 2;
    localparam int UART_DATA_W      = 8;

    function automatic int frame_len(input int data_w);
        return 1 + data_w + 1;
    endfunction

    localparam int UART_FRAME_LEN = frame_len(UART_DATA_W);

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable modulo-div counter: pulses tick on the last cycle of every bit period.
// Clearing restarts the period so the first bit after a grant is full length.
module uart_baud_tick #(
    parameter int DIV_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick  = !clr && (cnt_q == div - DIV_W'(1));
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 TX line between NUM_REQ clients,
// with a runtime baud divisor that only ever changes between frames.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int DIV_W       = UART_DIV_W,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [DIV_W-1:0]           cfg_div,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id,
    output logic                       tx
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int BIT_W = $clog2(DATA_W);

    uart_state_e       state_q;
    logic              tx_q;
    logic [ID_W-1:0]   cur_id_q;
    logic [ID_W-1:0]   rr_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_pend_q;
    logic              div_pend_vld_q;
    logic [DATA_W-1:0] shift_q;
    logic [BIT_W-1:0]  bit_q;

    logic              tick;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [DATA_W-1:0] gnt_data;
    logic [DIV_W-1:0]  cfg_div_clamped;

    // Scan from rr_q upward with wrap; the first requester found wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = rr_q;
        if (state_q == IDLE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
                cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
            end
        end
        gnt_vec  = '0;
        gnt_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_vec[k] = gnt_any && (gnt_id == ID_W'(k));
            if (gnt_id == ID_W'(k)) begin
                gnt_data = req_data[k*DATA_W +: DATA_W];
            end
        end
        rr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        cfg_div_clamped = (cfg_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : cfg_div;
    end

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (gnt_any),
        .div   (div_q),
        .tick  (tick)
    );

    // Case arms come after the config block so the IDLE-entry update of the divisor wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tx_q           <= 1'b1;
            cur_id_q       <= '0;
            rr_q           <= '0;
            div_q          <= DIV_W'(DEFAULT_DIV);
            div_pend_q     <= '0;
            div_pend_vld_q <= 1'b0;
            shift_q        <= '0;
            bit_q          <= '0;
        end else begin
            if (cfg_we) begin
                if (state_q == IDLE && !gnt_any) begin
                    div_q <= cfg_div_clamped;
                end else begin
                    div_pend_q     <= cfg_div_clamped;
                    div_pend_vld_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        cur_id_q <= gnt_id;
                        rr_q     <= rr_next;
                        shift_q  <= gnt_data;
                        bit_q    <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q        <= IDLE;
                        div_pend_vld_q <= 1'b0;
                        if (cfg_we) begin
                            div_q <= cfg_div_clamped;
                        end else if (div_pend_vld_q) begin
                            div_q <= div_pend_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant  = gnt_vec;
    assign busy   = (state_q != IDLE);
    assign cur_id = cur_id_q;
    assign tx     = tx_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: framing, round-robin order, divisor config,
// clamping, async reset abort and ignored short requests.
module tb_uart_tx_sched;

    logic        clk;
    logic        rst_n;
    logic        cfgWe;
    logic [13:0] cfgDiv;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  grant;
    logic        busy;
    logic [1:0]  curId;
    logic        tx;

    int compCount;
    int errCount;

    uart_tx_sched #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .DIV_W       (14),
        .DEFAULT_DIV (10416)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfgWe),
        .cfg_div  (cfgDiv),
        .req      (req),
        .req_data (reqData),
        .grant    (grant),
        .busy     (busy),
        .cur_id   (curId),
        .tx       (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic weV, input logic [13:0] divV);
        req    = reqV;
        cfgWe  = weV;
        cfgDiv = divV;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called in the grant cycle; walks every cycle of the frame and checks the line.
    task automatic checkFrame(input string tag, input logic [7:0] data, input int div, input int id,
                              input logic [3:0] reqAfter, input logic doCfg, input logic [13:0] cfgVal);
        logic expTx;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < div; j++) begin
                stepClock();
                expTx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1];
                checkOutput({tag, "_tx"}, 32'(tx), 32'(expTx));
                checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
                checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
                checkOutput({tag, "_curid"}, 32'(curId), 32'(id));
                if (b == 0 && j == 0) begin
                    applyStimulus(reqAfter, doCfg, cfgVal);
                end else begin
                    cfgWe = 1'b0;
                end
            end
        end
    endtask

    logic [7:0] clientData [4];
    int         expNext;

    initial begin
        compCount = 0;
        errCount  = 0;
        rst_n     = 1'b0;
        applyStimulus(4'b0000, 1'b0, 14'd0);
        clientData[0] = 8'h81;
        clientData[1] = 8'h0F;
        clientData[2] = 8'hC3;
        clientData[3] = 8'h3C;
        reqData = {clientData[3], clientData[2], clientData[1], 8'hA5};

        // Reset state
        repeat (3) stepClock();
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_curid", 32'(curId), 32'd0);
        rst_n = 1'b1;
        stepClock();

        // Single frame of 0xA5 at 4 cycles per bit
        applyStimulus(4'b0000, 1'b1, 14'd4);
        stepClock();
        applyStimulus(4'b0001, 1'b0, 14'd0);
        #1;
        checkOutput("t1_grant", 32'(grant), 32'h1);
        checkOutput("t1_busy0", 32'(busy), 32'd0);
        checkFrame("t1", 8'hA5, 4, 0, 4'b0000, 1'b0, 14'd0);
        stepClock();
        checkOutput("t1_end_busy", 32'(busy), 32'd0);
        checkOutput("t1_end_grant", 32'(grant), 32'd0);
        checkOutput("t1_end_tx", 32'(tx), 32'd1);
        checkOutput("t1_end_curid", 32'(curId), 32'd0);

        // Round-robin with all four requesting, then a mid-frame divisor write
        rst_n = 1'b0;
        stepClock();
        rst_n = 1'b1;
        reqData = {clientData[3], clientData[2], clientData[1], clientData[0]};
        applyStimulus(4'b0000, 1'b1, 14'd4);
        stepClock();
        applyStimulus(4'b1111, 1'b0, 14'd0);
        #1;
        checkOutput("t2_grant0", 32'(grant), 32'h1);
        for (int k = 0; k < 5; k++) begin
            checkFrame($sformatf("t2_f%0d", k), clientData[k % 4], 4, k % 4,
                       (k == 4) ? 4'b0001 : 4'b1111, (k == 4), 14'd6);
            stepClock();
            expNext = (k == 4) ? 0 : (k + 1) % 4;
            checkOutput($sformatf("t2_grant_after%0d", k), 32'(grant), 32'(4'(1) << expNext));
            checkOutput($sformatf("t2_busy_after%0d", k), 32'(busy), 32'd0);
        end
        checkFrame("t3", clientData[0], 6, 0, 4'b0000, 1'b0, 14'd0);
        stepClock();
        checkOutput("t3_end_busy", 32'(busy), 32'd0);

        // Divisor clamping: 0 and 1 both behave as 2
        applyStimulus(4'b0000, 1'b1, 14'd0);
        stepClock();
        applyStimulus(4'b0100, 1'b0, 14'd0);
        #1;
        checkOutput("t4a_grant", 32'(grant), 32'h4);
        checkFrame("t4a", clientData[2], 2, 2, 4'b0000, 1'b0, 14'd0);
        stepClock();
        applyStimulus(4'b0000, 1'b1, 14'd1);
        stepClock();
        applyStimulus(4'b1000, 1'b0, 14'd0);
        #1;
        checkOutput("t4b_grant", 32'(grant), 32'h8);
        checkFrame("t4b", clientData[3], 2, 3, 4'b0000, 1'b0, 14'd0);
        stepClock();
        checkOutput("t4b_end_busy", 32'(busy), 32'd0);
        checkOutput("t4b_end_curid", 32'(curId), 32'd3);

        // One-cycle req[2] pulse while busy is never served
        applyStimulus(4'b0001, 1'b0, 14'd0);
        #1;
        checkOutput("t6_grant", 32'(grant), 32'h1);
        stepClock();
        req = 4'b0100;
        stepClock();
        req = 4'b0000;
        for (int n = 0; n < 30; n++) begin
            stepClock();
            checkOutput($sformatf("t6_nogrant%0d", n), 32'(grant), 32'd0);
        end
        checkOutput("t6_idle_tx", 32'(tx), 32'd1);
        checkOutput("t6_idle_busy", 32'(busy), 32'd0);

        // Async reset during DATA bit 3, then defaults restored
        reqData = {clientData[3], clientData[2], 8'hF1, clientData[0]};
        applyStimulus(4'b0010, 1'b0, 14'd0);
        #1;
        checkOutput("t5_grant", 32'(grant), 32'h2);
        for (int n = 1; n <= 9; n++) begin
            stepClock();
            if (n == 1) req = 4'b0000;
        end
        checkOutput("t5_bit3_tx", 32'(tx), 32'd0);
        checkOutput("t5_bit3_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_tx", 32'(tx), 32'd1);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_grant", 32'(grant), 32'd0);
        repeat (2) stepClock();
        rst_n = 1'b1;
        stepClock();
        checkOutput("t5_rel_grant", 32'(grant), 32'd0);
        checkOutput("t5_rel_curid", 32'(curId), 32'd0);
        req = 4'b0110;
        #1;
        checkOutput("t5_rr_grant", 32'(grant), 32'h2);
        for (int n = 1; n <= 10417; n++) begin
            stepClock();
            if (n == 1) req = 4'b0000;
            if (n == 10416) checkOutput("t5_defdiv_start", 32'(tx), 32'd0);
            if (n == 10417) checkOutput("t5_defdiv_bit0", 32'(tx), 32'd1);
        end
        checkOutput("t5_defdiv_curid", 32'(curId), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_final_tx", 32'(tx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
